// File: rtl/multi_debouncer.sv
// Per-channel synchroniser + STABLE/CHANGE debounce FSM with edge, long-press and any-event pulses.
// Channels are fully independent; all outputs are registered.
module multi_debouncer #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 700_000,
  parameter int LONG_CYCLES     = 20_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press,
  output logic            any_event
);

  localparam int DW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = ($clog2(LONG_CYCLES + 1) < 1) ? 1 : $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // One-hot so that both 2'b00 and 2'b11 are detectably illegal.
  typedef enum logic [1:0] {
    ST_STABLE = 2'b01,
    ST_CHANGE = 2'b10
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    state_t                 state_q, state_nxt;
    logic [DW-1:0]          cnt_q, cnt_nxt;
    logic                   load;
    logic                   db_q, rise_q, fall_q, lp_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_nxt;
        cnt_q   <= cnt_nxt;
      end
    end

    always_comb begin
      state_nxt = ST_STABLE;
      case (state_q)
        ST_STABLE: state_nxt = (sync_in != db_q) ? ST_CHANGE : ST_STABLE;
        ST_CHANGE: state_nxt = (sync_in != db_q && cnt_q != D_LAST) ? ST_CHANGE : ST_STABLE;
        default:   state_nxt = ST_STABLE;
      endcase
    end

    // Counter clears on entry, abort and illegal states; it only advances in CHANGE.
    always_comb begin
      load    = 1'b0;
      cnt_nxt = '0;
      if (state_q == ST_CHANGE && sync_in != db_q) begin
        if (cnt_q == D_LAST) load = 1'b1;
        else                 cnt_nxt = cnt_q + DW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= load & sync_in;
        fall_q <= load & ~sync_in;
        if (load) db_q <= sync_in;
      end
    end

    if (LONG_CYCLES > 0) begin : g_long
      localparam logic [LW-1:0] L_MAX = LW'(LONG_CYCLES);
      localparam logic [LW-1:0] L_PRE = LW'(LONG_CYCLES - 1);
      logic [LW-1:0] hold_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_q <= '0;
          lp_q   <= 1'b0;
        end else begin
          lp_q <= db_q && (hold_q == L_PRE);
          if (!db_q)                hold_q <= '0;
          else if (hold_q != L_MAX) hold_q <= hold_q + LW'(1);
        end
      end
    end else begin : g_no_long
      assign lp_q = 1'b0;
    end

    assign db_out[i]     = db_q;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
    assign long_press[i] = lp_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_event <= 1'b0;
    else       any_event <= |(rise | fall);
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboarded bench: run-length reference model predicts every cycle, a monitor compares on negedge.
module tb_multi_debouncer;
  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] db_out, rise, fall, long_press;
  logic         any_event;

  multi_debouncer #(.N_CH(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .db_out(db_out), .rise(rise),
    .fall(fall), .long_press(long_press), .any_event(any_event)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] db;
    logic [N-1:0] rs;
    logic [N-1:0] fl;
    logic [N-1:0] lp;
    logic         any;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: btn delayed SYNC edges; db flips after DEB+1 consecutive differing samples.
  logic [N-1:0] pipe[$];
  logic [N-1:0] m_db, m_rise, m_fall, m_lp, s_now, db_old;
  logic         m_any;
  int           m_run[N];
  int           m_hold[N];
  obs_t         m_e;

  always @(posedge clk) begin
    if (reset) begin
      pipe = {};
      for (int k = 0; k < SYNC; k++) pipe.push_back('0);
      m_db = '0; m_rise = '0; m_fall = '0; m_lp = '0; m_any = 1'b0;
      for (int c = 0; c < N; c++) begin m_run[c] = 0; m_hold[c] = 0; end
    end else begin
      s_now = pipe.pop_front();
      pipe.push_back(btn_in);
      m_any  = |(m_rise | m_fall);
      db_old = m_db;
      m_rise = '0; m_fall = '0; m_lp = '0;
      for (int c = 0; c < N; c++) begin
        if (s_now[c] != m_db[c]) m_run[c]++;
        else                     m_run[c] = 0;
        if (m_run[c] == DEB + 1) begin
          m_db[c]   = s_now[c];
          m_rise[c] = s_now[c];
          m_fall[c] = ~s_now[c];
          m_run[c]  = 0;
        end
        if (db_old[c]) begin
          if (m_hold[c] < LONG) begin
            m_hold[c]++;
            if (m_hold[c] == LONG) m_lp[c] = 1'b1;
          end
        end else begin
          m_hold[c] = 0;
        end
      end
    end
    m_e.db = m_db; m_e.rs = m_rise; m_e.fl = m_fall; m_e.lp = m_lp; m_e.any = m_any;
    exp_q.push_back(m_e);
  end

  obs_t mon_e, mon_g;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_g.db = db_out; mon_g.rs = rise; mon_g.fl = fall; mon_g.lp = long_press; mon_g.any = any_event;
      vectors++;
      if (mon_g !== mon_e) begin
        miscompares++;
        $display("FAIL scoreboard @%0t got db=%b rise=%b fall=%b lp=%b any=%b want db=%b rise=%b fall=%b lp=%b any=%b",
                 $time, mon_g.db, mon_g.rs, mon_g.fl, mon_g.lp, mon_g.any,
                 mon_e.db, mon_e.rs, mon_e.fl, mon_e.lp, mon_e.any);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input int ch, output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rise[ch]) begin n = k; break; end
    end
  endtask

  task automatic wait_lp(input int ch, output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (long_press[ch]) begin n = k; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, bad, cnt;
    int rem[N];
    step(3);
    check("reset_outputs", {db_out, rise, fall, long_press, any_event}, 0);
    reset = 1'b0;
    step(10);

    // Short glitch must be rejected
    btn_in[0] = 1'b1; step(3); btn_in[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (rise[0] || any_event || db_out[0]) bad = 1;
    end
    check("glitch_quiet", bad, 0);

    step(1);
    btn_in[0] = 1'b1;
    wait_rise(0, n);
    check("rise0_latency", n, 7);
    check("db0_set", db_out[0], 1);
    check("ch1_idle", {db_out[1], rise[1]}, 0);
    @(posedge clk); #1;
    check("rise0_one_cycle", rise[0], 0);
    check("any_after_rise", any_event, 1);

    step(1);
    btn_in[1] = 1'b1;
    wait_rise(1, n);
    check("rise1_latency", n, 7);
    wait_lp(1, n);
    check("long_latency", n, 10);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (long_press[1]) cnt++;
    end
    check("long_no_repeat", cnt, 0);

    step(1);
    btn_in = '0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (fall != '0) begin n = k; break; end
    end
    check("fall_latency", n, 7);
    check("fall_both", fall, 2'b11);
    check("db_cleared", db_out, 2'b00);
    @(posedge clk); #1;
    check("any_after_fall", any_event, 1);
    check("fall_one_cycle", fall, 2'b00);

    step(2);
    btn_in[1] = 1'b1;
    wait_rise(1, n);
    check("rise1_again", n, 7);
    wait_lp(1, n);
    check("long_again", n, 10);

    // Reset while channel 0 sits in CHANGE with counter 2; channel 1 is debounced high
    step(1);
    btn_in[0] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("reset_async", {db_out, rise, fall, long_press, any_event}, 0);
    step(2);
    reset = 1'b0;
    wait_rise(0, n);
    check("rise_after_reset", n, 7);

    step(1);
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          btn_in[c] = ~btn_in[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 25) : $urandom_range(1, 7);
        end else begin
          rem[c]--;
        end
      end
      step(1);
    end
    btn_in = '0;
    step(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
